// File: rtl/result_hex_tx.sv
// Turns a 16-bit result into ASCII hex characters, optionally followed by CR LF,
// and hands them one at a time to the UART transmitter, pacing on tx_busy.
module result_hex_tx #(
    parameter bit CR_LF     = 1'b1,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger_tx,
    input  logic [15:0] data_in16,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    localparam logic [2:0] LAST_IDX  = CR_LF ? 3'd5 : 3'd3;
    localparam logic [7:0] ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_shadow, w_shadow_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [1:0]  r_ack_cnt, w_ack_cnt_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_tx_start, w_tx_start_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_overrun, w_overrun_nxt;
    logic [3:0]  w_nibble;
    logic [7:0]  w_char;

    always_comb begin
        w_nibble = 4'h0;
        w_char   = 8'h00;
        case (r_idx)
            3'd0: w_nibble = r_shadow[15:12];
            3'd1: w_nibble = r_shadow[11:8];
            3'd2: w_nibble = r_shadow[7:4];
            3'd3: w_nibble = r_shadow[3:0];
            default: w_nibble = 4'h0;
        endcase
        if (r_idx == 3'd4) begin
            w_char = 8'h0D;
        end else if (r_idx == 3'd5) begin
            w_char = 8'h0A;
        end else if (w_nibble < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nibble};
        end else begin
            w_char = ALPHA_BASE + {4'h0, w_nibble} - 8'd10;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shadow_nxt   = r_shadow;
        w_idx_nxt      = r_idx;
        w_ack_cnt_nxt  = r_ack_cnt;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        // A trigger that arrives while a frame is running is only reported.
        w_overrun_nxt  = trigger_tx && r_busy;

        case (r_state)
            S_IDLE: begin
                if (trigger_tx) begin
                    w_shadow_nxt = data_in16;
                    w_idx_nxt    = 3'd0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!tx_busy) begin
                    w_tx_data_nxt  = w_char;
                    w_tx_start_nxt = 1'b1;
                    w_ack_cnt_nxt  = 2'd0;
                    w_state_nxt    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Give up on seeing tx_busy after three idle cycles.
                if (tx_busy || r_ack_cnt == 2'd2) begin
                    w_state_nxt = S_WAIT_DONE;
                end else begin
                    w_ack_cnt_nxt = r_ack_cnt + 2'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_idx == LAST_IDX) begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_ack_cnt  <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_idx      <= w_idx_nxt;
            r_ack_cnt  <= w_ack_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_busy     <= w_busy_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_result_hex_tx.sv
// Bench for result_hex_tx: channel 0 uses CR_LF=1/UPPERCASE=1, channel 1 uses
// CR_LF=0/UPPERCASE=0; each channel has its own UART busy model and byte queue.
module tb_result_hex_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        trig [2];
    logic [15:0] din  [2];
    logic        txb  [2];
    logic [7:0]  txd  [2];
    logic        txs  [2];
    logic        bsy  [2];
    logic        ovr  [2];
    logic        frc  [2];
    int unsigned ulen [2];
    int unsigned ucnt [2] = '{0, 0};

    logic [7:0] exp_q [2][$];
    int tests = 0;
    int fails = 0;
    int strobes [2] = '{0, 0};
    int ovcnt   [2] = '{0, 0};
    int exp_ov  [2] = '{0, 0};
    logic prev_txs [2] = '{1'b0, 1'b0};
    logic prev_ovr [2] = '{1'b0, 1'b0};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        result_hex_tx #(
            .CR_LF    ((g == 0) ? 1'b1 : 1'b0),
            .UPPERCASE((g == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .trigger_tx(trig[g]),
            .data_in16 (din[g]),
            .tx_busy   (txb[g]),
            .tx_data   (txd[g]),
            .tx_start  (txs[g]),
            .busy      (bsy[g]),
            .overrun   (ovr[g])
        );

        assign txb[g] = frc[g] | (ucnt[g] != 0);

        // UART model: busy for ulen cycles after it samples tx_start.
        always @(posedge clk) begin
            if (txs[g] && ulen[g] != 0) ucnt[g] <= ulen[g];
            else if (ucnt[g] != 0)      ucnt[g] <= ucnt[g] - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ASCII hex digits MSB first, then CR LF where enabled.
    task automatic push_frame(input int ch, input logic [15:0] v);
        int n;
        for (int i = 0; i < 4; i++) begin
            n = (int'(v) >> (12 - 4 * i)) % 16;
            if (n < 10) exp_q[ch].push_back(8'(48 + n));
            else if (ch == 0) exp_q[ch].push_back(8'(65 + n - 10));
            else exp_q[ch].push_back(8'(97 + n - 10));
        end
        if (ch == 0) begin
            exp_q[ch].push_back(8'd13);
            exp_q[ch].push_back(8'd10);
        end
    endtask

    function automatic int frame_len(input int ch);
        return (ch == 0) ? 6 : 4;
    endfunction

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (txs[c]) begin
                strobes[c]++;
                check("tx_start_while_tx_busy", {31'd0, txb[c]}, 32'd0);
                check("tx_start_consecutive", {31'd0, prev_txs[c]}, 32'd0);
                if (exp_q[c].size() == 0) begin
                    check("unexpected_byte", {24'd0, txd[c]}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_data", {24'd0, txd[c]}, {24'd0, exp_q[c].pop_front()});
                end
            end
            if (ovr[c]) begin
                ovcnt[c]++;
                check("overrun_width", {31'd0, prev_ovr[c]}, 32'd0);
            end
            prev_txs[c] = txs[c];
            prev_ovr[c] = ovr[c];
        end
    end

    task automatic fire(input int ch, input logic [15:0] v, input bit accept);
        @(posedge clk); #1;
        din[ch]  = v;
        trig[ch] = 1'b1;
        if (accept) push_frame(ch, v);
        else exp_ov[ch]++;
        @(posedge clk); #1;
        trig[ch] = 1'b0;
        din[ch]  = 16'($urandom);
        if (accept) check("busy_after_trigger", {31'd0, bsy[ch]}, 32'd1);
    endtask

    task automatic wait_idle(input int ch);
        int n = 0;
        @(negedge clk);
        while (bsy[ch] === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("frame_completes", {31'd0, (n < 5000)}, 32'd1);
        check("leftover_bytes", exp_q[ch].size(), 32'd0);
    endtask

    task automatic frame(input int ch, input logic [15:0] v);
        int s0 = strobes[ch];
        fire(ch, v, 1'b1);
        wait_idle(ch);
        check("strobe_count", strobes[ch] - s0, frame_len(ch));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            trig[c] = 1'b0; din[c] = '0; frc[c] = 1'b0; ulen[c] = 10;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx_data", {24'd0, txd[0]}, 32'd0);
        check("reset_tx_start", {31'd0, txs[0]}, 32'd0);
        check("reset_busy", {31'd0, bsy[0]}, 32'd0);
        check("reset_overrun", {31'd0, ovr[0]}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed frames on both parameter sets
        frame(0, 16'h1A2F);
        frame(1, 16'hFFFF);
        frame(1, 16'h0000);

        // Second trigger during a frame is dropped and reported
        fire(0, 16'hABCD, 1'b1);
        repeat (5) @(posedge clk);
        fire(0, 16'h1234, 1'b0);
        wait_idle(0);
        check("overrun_count", ovcnt[0], exp_ov[0]);

        // Trigger in the first cycle after busy drops is accepted
        s0 = strobes[0];
        din[0] = 16'h7E57; trig[0] = 1'b1;
        push_frame(0, 16'h7E57);
        @(posedge clk); #1;
        trig[0] = 1'b0; din[0] = 16'h0000;
        check("busy_back_to_back", {31'd0, bsy[0]}, 32'd1);
        wait_idle(0);
        check("strobe_count_b2b", strobes[0] - s0, 32'd6);
        check("overrun_none_b2b", ovcnt[0], exp_ov[0]);

        // tx_busy held high before the first byte
        frc[0] = 1'b1;
        s0 = strobes[0];
        fire(0, 16'h5A5A, 1'b1);
        repeat (500) @(negedge clk);
        check("no_start_while_held", strobes[0] - s0, 32'd0);
        check("busy_while_held", {31'd0, bsy[0]}, 32'd1);
        @(posedge clk); #1;
        frc[0] = 1'b0;
        wait_idle(0);
        check("strobe_count_held", strobes[0] - s0, 32'd6);

        // UART that never raises tx_busy
        ulen[0] = 0; ulen[1] = 0;
        frame(0, 16'h9C3B);
        frame(1, 16'hD0E1);
        ulen[0] = 10; ulen[1] = 10;

        // Reset after the second byte aborts the frame
        s0 = strobes[0];
        fire(0, 16'hC0DE, 1'b1);
        n = 0;
        while (strobes[0] - s0 < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("second_byte_seen", {31'd0, (n < 2000)}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q[0].delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_tx_start", {31'd0, txs[0]}, 32'd0);
        check("abort_busy", {31'd0, bsy[0]}, 32'd0);
        check("abort_tx_data", {24'd0, txd[0]}, 32'd0);
        // Reset and trigger together: nothing captured
        @(posedge clk); #1;
        trig[0] = 1'b1; din[0] = 16'h4444;
        @(posedge clk); #1;
        trig[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("reset_wins_busy", {31'd0, bsy[0]}, 32'd0);
        frame(0, 16'hBEEF);

        // Randomized frames with random UART busy lengths
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < 2; c++) begin
                ulen[c] = $urandom_range(0, 12);
                frame(c, 16'($urandom));
            end
        end
        check("overrun_total_ch0", ovcnt[0], exp_ov[0]);
        check("overrun_total_ch1", ovcnt[1], exp_ov[1]);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
